// File: rtl/l2tlb_xlat_pkg.sv
// Shared FSM state codes, fault codes and PTE helpers for the L2TLB translation stage.
package l2tlb_xlat_pkg;

    typedef logic [2:0] l2tlb_state_t;

    localparam l2tlb_state_t ST_IDLE  = 3'd0;
    localparam l2tlb_state_t ST_CHK   = 3'd1;
    localparam l2tlb_state_t ST_SNOOP = 3'd2;
    localparam l2tlb_state_t ST_SWAIT = 3'd3;
    localparam l2tlb_state_t ST_WALK  = 3'd4;
    localparam l2tlb_state_t ST_WAIT  = 3'd5;
    localparam l2tlb_state_t ST_ACK   = 3'd6;

    typedef logic [2:0] l2tlb_fault_t;

    localparam l2tlb_fault_t FAULT_OK      = 3'b000;
    localparam l2tlb_fault_t FAULT_INV_PTE = 3'b001;

    function automatic logic pte_valid(input logic [63:0] pte);
        return pte[0];
    endfunction

endpackage

// File: rtl/l2tlb_sptbr_slots.sv
// SPTBR-to-slot CAM: combinational match / lowest-free / round-robin victim, registered bind.
// Bind and RR advance take effect at the next edge; no flow control of its own.
module l2tlb_sptbr_slots #(
    parameter int NUM_SPTBR = 4,
    parameter int SPTBR_W   = 38,
    parameter int SID_W     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPTBR_W-1:0] sptbr,
    output logic               hit,
    output logic [SID_W-1:0]   hit_sid,
    output logic               free,
    output logic [SID_W-1:0]   free_sid,
    output logic [SID_W-1:0]   victim_sid,
    input  logic               bind_en,
    input  logic [SID_W-1:0]   bind_sid,
    input  logic               advance
);

    logic               vld [NUM_SPTBR];
    logic [SPTBR_W-1:0] tag [NUM_SPTBR];
    logic [SID_W-1:0]   rr;

    always_comb begin
        hit      = 1'b0;
        hit_sid  = '0;
        free     = 1'b0;
        free_sid = '0;
        for (int i = 0; i < NUM_SPTBR; i++) begin
            if (vld[i] && tag[i] == sptbr) begin
                hit     = 1'b1;
                hit_sid = SID_W'(i);
            end
        end
        // Descending scan so the lowest free index wins.
        for (int i = NUM_SPTBR - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                free     = 1'b1;
                free_sid = SID_W'(i);
            end
        end
    end

    assign victim_sid = rr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPTBR; i++) begin
                vld[i] <= 1'b0;
                tag[i] <= '0;
            end
            rr <= '0;
        end else begin
            if (bind_en) begin
                vld[bind_sid] <= 1'b1;
                tag[bind_sid] <= sptbr;
            end
            if (advance) begin
                rr <= rr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2tlb_xlat.sv
// L2TLB: fully-associative SPTBR-slot-tagged translation array, single-level PTE walk, slot-flush snoop.
// Hit ack 2 cycles after request accept; one request outstanding, req_retry high outside IDLE.
module l2tlb_xlat
    import l2tlb_xlat_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_SPTBR   = 4,
    parameter int RID_W       = 4,
    parameter int LADDR_W     = 39,
    parameter int PADDR_W     = 50,
    parameter int SPTBR_W     = 38,
    parameter int NID_W       = 5,
    parameter logic [NID_W-1:0] NODE_ID = NID_W'(1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_retry,
    input  logic [RID_W-1:0]             req_rid,
    input  logic [LADDR_W-1:0]           req_laddr,
    input  logic [SPTBR_W-1:0]           req_sptbr,
    output logic                         ack_valid,
    input  logic                         ack_retry,
    output logic [RID_W-1:0]             ack_rid,
    output logic [PADDR_W-13:0]          ack_ppn,
    output logic [2:0]                   ack_fault,
    output logic                         snoop_valid,
    input  logic                         snoop_retry,
    output logic [$clog2(NUM_SPTBR)-1:0] snoop_sid,
    input  logic                         sack_valid,
    output logic                         sack_retry,
    output logic                         walk_valid,
    input  logic                         walk_retry,
    output logic [NID_W-1:0]             walk_nid,
    output logic [PADDR_W-1:0]           walk_paddr,
    input  logic                         dack_valid,
    output logic                         dack_retry,
    input  logic [63:0]                  dack_pte
);

    localparam int SID_W  = $clog2(NUM_SPTBR);
    localparam int EIDX_W = $clog2(NUM_ENTRIES);
    localparam int VPN_W  = LADDR_W - 12;
    localparam int PPN_W  = PADDR_W - 12;

    typedef struct packed {
        logic             valid;
        logic [SID_W-1:0] sid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
    } l2tlb_entry_t;

    l2tlb_state_t       state, state_nxt;
    logic [RID_W-1:0]   lat_rid;
    logic [VPN_W-1:0]   lat_vpn;
    logic [SPTBR_W-1:0] lat_sptbr;
    logic [SID_W-1:0]   cur_sid;
    l2tlb_entry_t       ent [NUM_ENTRIES];
    logic [EIDX_W-1:0]  ent_rr;

    logic               slot_hit, slot_free, bind_en, slot_adv;
    logic [SID_W-1:0]   slot_hit_sid, slot_free_sid, slot_victim, bind_sid, sid_res;
    logic               arr_hit, fill_free;
    logic [EIDX_W-1:0]  arr_idx, fill_idx;
    logic [PADDR_W-1:0] walk_addr;
    logic [PPN_W-1:0]   pte_ppn;
    logic               unused_bits;

    assign unused_bits = ^{dack_pte[63:PPN_W+10], dack_pte[9:1], req_laddr[11:0], NODE_ID[0]};
    assign pte_ppn     = dack_pte[PPN_W+9:10];
    // Carry out of the PTE address sum is intentionally dropped by the truncating casts.
    assign walk_addr   = PADDR_W'({lat_sptbr, 12'b0}) + PADDR_W'({lat_vpn, 3'b0});

    l2tlb_sptbr_slots #(
        .NUM_SPTBR (NUM_SPTBR),
        .SPTBR_W   (SPTBR_W),
        .SID_W     (SID_W)
    ) u_slots (
        .clk        (clk),
        .reset      (reset),
        .sptbr      (lat_sptbr),
        .hit        (slot_hit),
        .hit_sid    (slot_hit_sid),
        .free       (slot_free),
        .free_sid   (slot_free_sid),
        .victim_sid (slot_victim),
        .bind_en    (bind_en),
        .bind_sid   (bind_sid),
        .advance    (slot_adv)
    );

    always_comb begin
        if (slot_hit)       sid_res = slot_hit_sid;
        else if (slot_free) sid_res = slot_free_sid;
        else                sid_res = slot_victim;
    end

    always_comb begin
        arr_hit = 1'b0;
        arr_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent[i].valid && ent[i].sid == sid_res && ent[i].vpn == lat_vpn) begin
                arr_hit = 1'b1;
                arr_idx = EIDX_W'(i);
            end
        end
    end

    always_comb begin
        fill_free = 1'b0;
        fill_idx  = ent_rr;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!ent[i].valid) begin
                fill_free = 1'b1;
                fill_idx  = EIDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        bind_en   = 1'b0;
        bind_sid  = sid_res;
        slot_adv  = 1'b0;
        case (state)
            ST_IDLE:  if (req_valid && !req_retry) state_nxt = ST_CHK;
            ST_CHK: begin
                if (slot_hit || slot_free) begin
                    bind_en   = !slot_hit;
                    state_nxt = arr_hit ? ST_ACK : ST_WALK;
                end else begin
                    state_nxt = ST_SNOOP;
                end
            end
            ST_SNOOP: if (snoop_valid && !snoop_retry) state_nxt = ST_SWAIT;
            ST_SWAIT: begin
                if (sack_valid && !sack_retry) begin
                    bind_en   = 1'b1;
                    bind_sid  = cur_sid;
                    slot_adv  = 1'b1;
                    state_nxt = ST_CHK;
                end
            end
            ST_WALK:  if (walk_valid && !walk_retry) state_nxt = ST_WAIT;
            ST_WAIT:  if (dack_valid && !dack_retry) state_nxt = ST_ACK;
            ST_ACK:   if (ack_valid && !ack_retry) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            lat_rid     <= '0;
            lat_vpn     <= '0;
            lat_sptbr   <= '0;
            cur_sid     <= '0;
            ent_rr      <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
            req_retry   <= 1'b0;
            ack_valid   <= 1'b0;
            ack_rid     <= '0;
            ack_ppn     <= '0;
            ack_fault   <= FAULT_OK;
            snoop_valid <= 1'b0;
            snoop_sid   <= '0;
            sack_retry  <= 1'b1;
            walk_valid  <= 1'b0;
            walk_nid    <= '0;
            walk_paddr  <= '0;
            dack_retry  <= 1'b1;
        end else begin
            state       <= state_nxt;
            // Handshake outputs follow the next state so they are registered yet cycle-accurate.
            req_retry   <= (state_nxt != ST_IDLE);
            ack_valid   <= (state_nxt == ST_ACK);
            snoop_valid <= (state_nxt == ST_SNOOP);
            sack_retry  <= (state_nxt != ST_SWAIT);
            walk_valid  <= (state_nxt == ST_WALK);
            dack_retry  <= (state_nxt != ST_WAIT);
            case (state)
                ST_IDLE: begin
                    if (req_valid && !req_retry) begin
                        lat_rid   <= req_rid;
                        lat_vpn   <= req_laddr[LADDR_W-1:12];
                        lat_sptbr <= req_sptbr;
                    end
                end
                ST_CHK: begin
                    cur_sid <= sid_res;
                    if (state_nxt == ST_ACK) begin
                        ack_rid   <= lat_rid;
                        ack_ppn   <= ent[arr_idx].ppn;
                        ack_fault <= FAULT_OK;
                    end
                    if (state_nxt == ST_SNOOP) snoop_sid <= sid_res;
                    if (state_nxt == ST_WALK) begin
                        walk_paddr <= walk_addr;
                        walk_nid   <= {NODE_ID[NID_W-1:1], 1'b1};
                    end
                end
                ST_SWAIT: begin
                    if (sack_valid && !sack_retry) begin
                        for (int i = 0; i < NUM_ENTRIES; i++) begin
                            if (ent[i].sid == cur_sid) ent[i].valid <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dack_valid && !dack_retry) begin
                        ack_rid <= lat_rid;
                        if (pte_valid(dack_pte)) begin
                            ent[fill_idx] <= '{valid: 1'b1, sid: cur_sid, vpn: lat_vpn, ppn: pte_ppn};
                            if (!fill_free) ent_rr <= ent_rr + 1'b1;
                            ack_ppn   <= pte_ppn;
                            ack_fault <= FAULT_OK;
                        end else begin
                            ack_ppn   <= '0;
                            ack_fault <= FAULT_INV_PTE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2tlb_xlat.sv
// Bench for l2tlb_xlat: directed vector table, reset-in-WAIT sequence, RR replacement and random traffic vs a model.
module tb_l2tlb_xlat;

    localparam int NE = 16;
    localparam int NS = 4;

    logic        clk, reset;
    logic        req_valid, req_retry;
    logic [3:0]  req_rid;
    logic [38:0] req_laddr;
    logic [37:0] req_sptbr;
    logic        ack_valid, ack_retry;
    logic [3:0]  ack_rid;
    logic [37:0] ack_ppn;
    logic [2:0]  ack_fault;
    logic        snoop_valid, snoop_retry;
    logic [1:0]  snoop_sid;
    logic        sack_valid, sack_retry;
    logic        walk_valid, walk_retry;
    logic [4:0]  walk_nid;
    logic [49:0] walk_paddr;
    logic        dack_valid, dack_retry;
    logic [63:0] dack_pte;

    int n_checks = 0;
    int n_fail   = 0;

    l2tlb_xlat dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_retry(req_retry), .req_rid(req_rid),
        .req_laddr(req_laddr), .req_sptbr(req_sptbr),
        .ack_valid(ack_valid), .ack_retry(ack_retry), .ack_rid(ack_rid),
        .ack_ppn(ack_ppn), .ack_fault(ack_fault),
        .snoop_valid(snoop_valid), .snoop_retry(snoop_retry), .snoop_sid(snoop_sid),
        .sack_valid(sack_valid), .sack_retry(sack_retry),
        .walk_valid(walk_valid), .walk_retry(walk_retry), .walk_nid(walk_nid),
        .walk_paddr(walk_paddr),
        .dack_valid(dack_valid), .dack_retry(dack_retry), .dack_pte(dack_pte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Results of the last transaction
    logic        r_done, r_snoop, r_walk;
    logic [1:0]  r_sid;
    logic [49:0] r_paddr;
    logic [4:0]  r_nid;
    logic [3:0]  r_rid;
    logic [37:0] r_ppn;
    logic [2:0]  r_fault;
    int          r_lat;

    task automatic do_xlat(input logic [3:0] rid, input logic [38:0] laddr, input logic [37:0] sptbr,
                           input logic [63:0] pte, input int sack_hold, input int ack_hold);
        int n;
        int snoop_at;
        r_done = 0; r_snoop = 0; r_walk = 0; r_sid = 0; r_paddr = 0; r_nid = 0;
        r_rid = 0; r_ppn = 0; r_fault = 0; r_lat = 0; snoop_at = 0;
        n = 0;
        while (req_retry && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (req_retry) begin
            chk("req_accept_timeout", req_retry, 0);
            return;
        end
        req_valid = 1; req_rid = rid; req_laddr = laddr; req_sptbr = sptbr;
        @(negedge clk);
        req_valid = 0;
        n = 1;
        while (!r_done && n < 300) begin
            if (snoop_valid && !r_snoop) begin
                r_snoop = 1; r_sid = snoop_sid; snoop_at = n;
            end
            sack_valid = r_snoop && (n >= snoop_at + sack_hold);
            if (r_snoop && !sack_valid) chk("req_retry_in_sack_hold", req_retry, 1);
            if (walk_valid && !r_walk) begin
                r_walk = 1; r_paddr = walk_paddr; r_nid = walk_nid;
            end
            dack_valid = r_walk;
            dack_pte   = pte;
            if (ack_valid) begin
                if (r_lat == 0) begin
                    r_lat = n; r_rid = ack_rid; r_ppn = ack_ppn; r_fault = ack_fault;
                end else begin
                    chk("ack_stable", {ack_rid, ack_ppn, ack_fault}, {r_rid, r_ppn, r_fault});
                    chk("req_retry_in_ack_hold", req_retry, 1);
                end
                ack_retry = (n < r_lat + ack_hold);
                if (!ack_retry) r_done = 1;
            end
            @(negedge clk);
            n++;
        end
        ack_retry = 0; sack_valid = 0; dack_valid = 0;
        if (!r_done) chk("xlat_timeout", 0, 1);
    endtask

    // Reference model: slots hold SPTBR values, entries are tagged by SPTBR directly.
    logic        m_bound [NS];
    logic [37:0] m_tag   [NS];
    int          m_srr;
    logic        m_v     [NE];
    logic [37:0] m_sp    [NE];
    logic [26:0] m_vpn   [NE];
    logic [37:0] m_ppn   [NE];
    int          m_err;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin m_bound[s] = 0; m_tag[s] = 0; end
        for (int i = 0; i < NE; i++) begin m_v[i] = 0; m_sp[i] = 0; m_vpn[i] = 0; m_ppn[i] = 0; end
        m_srr = 0; m_err = 0;
    endtask

    task automatic run_model(input logic [3:0] rid, input logic [38:0] laddr, input logic [37:0] sptbr,
                             input logic [63:0] pte, input int sh, input int ah);
        logic        e_snoop, e_walk;
        logic [1:0]  e_sid;
        logic [49:0] e_paddr;
        logic [37:0] e_ppn;
        logic [2:0]  e_fault;
        logic [26:0] vpn;
        int slot, hit, idx;
        vpn = laddr[38:12];
        e_snoop = 0; e_sid = 0; e_walk = 0; e_paddr = 0; slot = -1; hit = -1;
        for (int s = 0; s < NS; s++) if (m_bound[s] && m_tag[s] == sptbr) slot = s;
        if (slot < 0) for (int s = NS - 1; s >= 0; s--) if (!m_bound[s]) slot = s;
        if (slot < 0) begin
            slot = m_srr; e_snoop = 1; e_sid = 2'(slot);
            for (int i = 0; i < NE; i++) if (m_sp[i] == m_tag[slot]) m_v[i] = 0;
            m_srr = (m_srr + 1) % NS;
        end
        m_bound[slot] = 1; m_tag[slot] = sptbr;
        for (int i = 0; i < NE; i++) if (m_v[i] && m_sp[i] == sptbr && m_vpn[i] == vpn) hit = i;
        if (hit >= 0) begin
            e_ppn = m_ppn[hit]; e_fault = 0;
        end else begin
            e_walk  = 1;
            e_paddr = 50'((64'(sptbr) << 12) + (64'(vpn) << 3));
            if (pte[0]) begin
                idx = -1;
                for (int i = NE - 1; i >= 0; i--) if (!m_v[i]) idx = i;
                if (idx < 0) begin idx = m_err; m_err = (m_err + 1) % NE; end
                m_v[idx] = 1; m_sp[idx] = sptbr; m_vpn[idx] = vpn; m_ppn[idx] = pte[47:10];
                e_ppn = pte[47:10]; e_fault = 0;
            end else begin
                e_ppn = 0; e_fault = 1;
            end
        end
        do_xlat(rid, laddr, sptbr, pte, sh, ah);
        chk("m_snoop", r_snoop, e_snoop);
        if (e_snoop) chk("m_snoop_sid", r_sid, e_sid);
        chk("m_walk", r_walk, e_walk);
        if (e_walk) chk("m_walk_paddr", r_paddr, e_paddr);
        chk("m_ack_rid", r_rid, rid);
        chk("m_ack_ppn", r_ppn, e_ppn);
        chk("m_ack_fault", r_fault, e_fault);
    endtask

    typedef struct {
        logic [3:0]  rid;
        logic [38:0] laddr;
        logic [37:0] sptbr;
        logic [63:0] pte;
        int          sack_hold;
        int          ack_hold;
        logic        exp_snoop;
        logic [1:0]  exp_sid;
        logic        exp_walk;
        logic [49:0] exp_paddr;
        logic [37:0] exp_ppn;
        logic [2:0]  exp_fault;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [3:0]  rr_rid;
        logic [38:0] rr_laddr;
        logic [63:0] rr_pte;
        int n;

        vecs[0]  = '{4'd3, 39'h5000, 38'h10, 64'h401,  0,  0, 1'b0, 2'd0, 1'b1, 50'h10028, 38'h1, 3'd0, 0};
        vecs[1]  = '{4'd3, 39'h5000, 38'h10, 64'h401,  0,  0, 1'b0, 2'd0, 1'b0, 50'h0,     38'h1, 3'd0, 2};
        vecs[2]  = '{4'd1, 39'h7000, 38'h20, 64'h801,  0,  0, 1'b0, 2'd0, 1'b1, 50'h20038, 38'h2, 3'd0, 0};
        vecs[3]  = '{4'd2, 39'h7000, 38'h30, 64'hC01,  0,  0, 1'b0, 2'd0, 1'b1, 50'h30038, 38'h3, 3'd0, 0};
        vecs[4]  = '{4'd4, 39'h1000, 38'h40, 64'h1001, 0,  0, 1'b0, 2'd0, 1'b1, 50'h40008, 38'h4, 3'd0, 0};
        vecs[5]  = '{4'd5, 39'h2000, 38'h50, 64'h1401, 10, 0, 1'b1, 2'd0, 1'b1, 50'h50010, 38'h5, 3'd0, 0};
        vecs[6]  = '{4'd3, 39'h5000, 38'h10, 64'h401,  0,  0, 1'b1, 2'd1, 1'b1, 50'h10028, 38'h1, 3'd0, 0};
        vecs[7]  = '{4'd6, 39'h9000, 38'h30, 64'h400,  0,  0, 1'b0, 2'd0, 1'b1, 50'h30048, 38'h0, 3'd1, 0};
        vecs[8]  = '{4'd6, 39'h9000, 38'h30, 64'h2401, 0,  0, 1'b0, 2'd0, 1'b1, 50'h30048, 38'h9, 3'd0, 0};
        vecs[9]  = '{4'd7, 39'h7000, 38'h30, 64'h0,    0,  5, 1'b0, 2'd0, 1'b0, 50'h0,     38'h3, 3'd0, 2};
        vecs[10] = '{4'd8, 39'h1000, 38'h40, 64'h0,    0,  0, 1'b0, 2'd0, 1'b0, 50'h0,     38'h4, 3'd0, 2};

        reset = 0; req_valid = 0; req_rid = 0; req_laddr = 0; req_sptbr = 0;
        ack_retry = 0; snoop_retry = 0; sack_valid = 0; walk_retry = 0; dack_valid = 0; dack_pte = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_retry", req_retry, 0);
        chk("rst_valids", {ack_valid, snoop_valid, walk_valid}, 0);
        chk("rst_retries", {sack_retry, dack_retry}, 2'b11);
        chk("rst_payloads", {ack_rid, ack_ppn, ack_fault, snoop_sid, walk_nid, walk_paddr}, 0);
        reset = 1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            do_xlat(vecs[i].rid, vecs[i].laddr, vecs[i].sptbr, vecs[i].pte, vecs[i].sack_hold, vecs[i].ack_hold);
            chk($sformatf("v%0d_snoop", i), r_snoop, vecs[i].exp_snoop);
            if (vecs[i].exp_snoop) chk($sformatf("v%0d_snoop_sid", i), r_sid, vecs[i].exp_sid);
            chk($sformatf("v%0d_walk", i), r_walk, vecs[i].exp_walk);
            if (vecs[i].exp_walk) begin
                chk($sformatf("v%0d_walk_paddr", i), r_paddr, vecs[i].exp_paddr);
                chk($sformatf("v%0d_walk_nid", i), r_nid, 5'd1);
            end
            chk($sformatf("v%0d_ack_rid", i), r_rid, vecs[i].rid);
            chk($sformatf("v%0d_ack_ppn", i), r_ppn, vecs[i].exp_ppn);
            chk($sformatf("v%0d_ack_fault", i), r_fault, vecs[i].exp_fault);
            if (vecs[i].exp_lat != 0) chk($sformatf("v%0d_hit_latency", i), r_lat, vecs[i].exp_lat);
        end

        // Reset while waiting for PTE data
        sack_valid = 1;
        req_valid = 1; req_rid = 4'd9; req_laddr = 39'hA000; req_sptbr = 38'h60;
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (!walk_valid && n < 50) begin @(negedge clk); n++; end
        sack_valid = 0;
        chk("rst_wait_walk_seen", walk_valid, 1);
        @(negedge clk);
        chk("rst_wait_dack_retry", dack_retry, 0);
        reset = 0;
        @(negedge clk);
        chk("rst_mid_valids", {ack_valid, snoop_valid, walk_valid}, 0);
        chk("rst_mid_retries", {req_retry, sack_retry, dack_retry}, 3'b011);
        reset = 1;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_ack", ack_valid, 0);
        model_reset();

        run_model(4'd9, 39'hA000, 38'h60, 64'h3001, 0, 0);
        chk("post_rst_walks", r_walk, 1);

        // Fill the array with 16 further misses, then the first VPN is the RR victim
        for (int i = 0; i < NE; i++) begin
            rr_rid   = 4'(i);
            rr_laddr = 39'((64'h100 + 64'(i)) << 12);
            rr_pte   = 64'((64'h200 + 64'(i)) << 10) | 64'h1;
            run_model(rr_rid, rr_laddr, 38'h60, rr_pte, 0, 0);
        end
        run_model(4'd10, 39'hA000, 38'h60, 64'h3001, 0, 0);
        chk("rr_first_vpn_rewalks", r_walk, 1);
        run_model(4'd11, 39'h102000, 38'h60, 64'h0, 0, 0);
        chk("rr_survivor_hits", r_walk, 0);

        for (int t = 0; t < 120; t++) begin
            rr_rid   = 4'($urandom);
            rr_laddr = {27'($urandom_range(0, 11)), 12'($urandom)};
            rr_pte   = {16'h0, 38'({$urandom, $urandom}), 9'h0, 1'($urandom_range(0, 7) != 0)};
            run_model(rr_rid, rr_laddr, 38'h100 + 38'($urandom_range(0, 5)), rr_pte,
                      $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
